ksa_mw_seq: RTL and testbench
=============================

Name: ksa_mw_seq

Overview:
- Multi-word add/subtract sequencer built around one shared 32-bit Kogge-Stone adder.
- Latches two WORDS×32-bit operands and feeds them to the adder one 32-bit word at a time, least-significant word first.
- The carry-out of each word becomes the carry-in (c0) of the next word.
- Collects the per-word sums into a wide result and reports carry-out and signed overflow.
- Sits between a requesting client (start/ready/done handshake) and the adder datapath (an optionally pipelined chain of Kogge-Stone stages).

Parameters:
- WORDS, 4, number of 32-bit words per operand (≥1); operand width W = 32*WORDS
- LAT, 1, adder latency in clock cycles from operands presented to sum valid (0 = combinational)

Ports:
- i_clk  input  1  clock
- i_rst_n  input  1  reset
- i_start  input  1  request; accepted when i_start & o_ready
- i_a  input  W  operand A, sampled on accept
- i_b  input  W  operand B, sampled on accept
- i_sub  input  1  1 = A−B, 0 = A+B+i_cin; sampled on accept
- i_cin  input  1  carry-in for add; ignored when i_sub=1
- o_ready  output  1  high in IDLE and DONE
- o_busy  output  1  high in ISSUE and WAIT
- o_done  output  1  one-cycle pulse; result valid
- o_sum  output  W  result; held until next accept
- o_cout  output  1  carry-out of top word (sub: 1 = no borrow)
- o_ovf  output  1  signed overflow
- o_add_a  output  32  adder operand A word
- o_add_b  output  32  adder operand B word (inverted for sub)
- o_add_c0  output  1  adder carry-in
- i_add_s  input  32  adder sum
- i_add_cout  input  1  adder carry-out

Behaviour:
- Clocking and reset:
  - One clock, i_clk.
  - Reset i_rst_n is synchronous and active-low.
  - On reset: state=IDLE; o_sum=0, o_cout=0, o_ovf=0, o_done=0, o_busy=0; o_add_a=0, o_add_b=0, o_add_c0=0.
  - Reset asserted mid-operation aborts the operation: the next cycle is IDLE with all outputs at reset values, and no o_done is produced.
- States:
  - IDLE: o_ready=1. On accept:
    - latch A; latch B, or ~B when i_sub=1
    - carry register = i_sub ? 1 : i_cin
    - idx=0; clear o_sum, o_cout, o_ovf
    - go to ISSUE
  - ISSUE:
    - drive o_add_a=A[idx], o_add_b=Beff[idx], o_add_c0=carry
    - LAT=0: capture i_add_s into o_sum[idx] and i_add_cout into carry in this same cycle, then advance
    - LAT>0: load wait counter = LAT, go to WAIT
  - WAIT:
    - operands held stable; counter decrements each cycle
    - in the cycle the counter reaches 1 (i.e. LAT cycles after the ISSUE cycle): capture i_add_s and i_add_cout, then advance
  - Advance:
    - idx<WORDS−1: idx++, go to ISSUE
    - otherwise: go to DONE
  - DONE (1 cycle):
    - o_done=1; o_cout = last carry
    - o_ovf = (A_msb == Beff_msb) & (sum_msb != A_msb)
    - o_ready=1; an accept in DONE starts a new operation, going directly to ISSUE
    - otherwise go to IDLE
- Adder drive outside ISSUE/WAIT: o_add_a, o_add_b, o_add_c0 are driven to 0.
- Timing: each word takes LAT+1 cycles. With accept at cycle 0:
  - word k is issued at cycle 1+k(LAT+1)
  - o_done pulses at cycle 1+WORDS(LAT+1)
  - with defaults, o_done at cycle 9
  - back-to-back throughput: one operation per WORDS(LAT+1)+1 cycles
- Handshake edge cases: i_start while o_busy=1 is ignored and has no effect on the operation in flight.
- Inputs after accept: i_a, i_b, i_sub and i_cin may change freely; only the values latched at accept are used.
- Result stability: o_sum is partially updated during ISSUE/WAIT and is valid only from o_done until the next accept. o_cout and o_ovf change only in DONE.
- Width rules: idx is clog2(WORDS) bits wide (minimum 1); the wait counter is clog2(LAT+1) bits wide. No wrap beyond WORDS−1.

Test Plan:
- Ripple-carry check (defaults): A=2^128−1, B=1, i_sub=0, i_cin=0 → o_done at cycle 9, o_sum=0, o_cout=1, o_ovf=0; adder c0 sequence 0,1,1,1.
- Subtract with borrow: A=5, B=7, i_sub=1 → o_sum=2^128−2, o_cout=0, o_ovf=0.
- Signed overflow: A=0x7FFF…FFFF, B=1, add → o_sum=0x8000…0000, o_ovf=1, o_cout=0. Then A=0x8000…0, B=1, sub → o_sum=0x7FFF…F, o_ovf=1.
- Handshake:
  - i_start held high throughout with A=1, B=2, then A=3, B=4 → accepts at cycles 0 and 9, o_done at cycles 9 and 18, results 3 then 7.
  - An extra i_start pulse at cycle 3 causes no disturbance.
- Reset mid-operation: i_rst_n=0 at cycle 4 → cycle 5: IDLE, o_ready=1, o_sum=0, o_add_*=0, no o_done. A subsequent A=10, B=20 add returns 30.
- LAT=0 build, WORDS=2: A=0xFFFFFFFF, B=1 → o_done at cycle 3, o_sum=0x1_00000000, o_cout=0.

Source files
------------

// File: rtl/ksa_mw_seq.sv
// ksa_mw_seq: multi-word add/subtract sequencer feeding one shared 32-bit adder LSW first
module ksa_mw_seq #(
  parameter int WORDS = 4,
  parameter int LAT   = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [32*WORDS-1:0]   i_a,
  input  logic [32*WORDS-1:0]   i_b,
  input  logic                  i_sub,
  input  logic                  i_cin,
  output logic                  o_ready,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [32*WORDS-1:0]   o_sum,
  output logic                  o_cout,
  output logic                  o_ovf,
  output logic [31:0]           o_add_a,
  output logic [31:0]           o_add_b,
  output logic                  o_add_c0,
  input  logic [31:0]           i_add_s,
  input  logic                  i_add_cout
);
  localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
  localparam int CW = LAT > 0 ? $clog2(LAT + 1) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t state, state_nx;
  logic [WORDS-1:0][31:0] a_q, b_q, sum_q;
  logic carry;
  logic [IW-1:0] idx;
  logic [CW-1:0] cnt;
  logic accept, cap, last, busy;
  assign o_sum = sum_q;
  always_comb begin
    o_ready  = state == IDLE || state == DONE;
    busy     = state == ISSUE || state == WAIT;
    o_busy   = busy;
    o_done   = state == DONE;
    accept   = i_start & o_ready;
    last     = idx == IW'(WORDS - 1);
    cap      = (state == ISSUE && LAT == 0) || (state == WAIT && cnt == CW'(1));
    o_add_a  = busy ? a_q[idx] : '0;
    o_add_b  = busy ? b_q[idx] : '0;
    o_add_c0 = busy & carry;
    state_nx = o_ready ? (accept ? ISSUE : IDLE)
             : cap ? (last ? DONE : ISSUE)
             : state == ISSUE ? WAIT : state;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      cnt    <= '0;
      o_cout <= 1'b0;
      o_ovf  <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        a_q    <= i_a;
        b_q    <= i_sub ? ~i_b : i_b;
        carry  <= i_sub | i_cin;
        idx    <= '0;
        sum_q  <= '0;
        o_cout <= 1'b0;
        o_ovf  <= 1'b0;
      end
      if (state == ISSUE) cnt <= CW'(LAT);
      else if (state == WAIT) cnt <= cnt - CW'(1);
      // final word also settles the flags so they are valid together with o_done
      if (cap) begin
        sum_q[idx] <= i_add_s;
        carry      <= i_add_cout;
        idx        <= last ? idx : idx + IW'(1);
        if (last) begin
          o_cout <= i_add_cout;
          o_ovf  <= (a_q[WORDS-1][31] == b_q[WORDS-1][31]) & (i_add_s[31] != a_q[WORDS-1][31]);
        end
      end
    end
  end
endmodule

// File: tb/tb_ksa_mw_seq.sv
// tb_ksa_mw_seq: directed bench with a cycle-level arithmetic model for ksa_mw_seq
module tb_ksa_mw_seq;
  localparam int WORDS = 4, LAT = 1, W = 128, N = 1 + WORDS * (LAT + 1);
  logic clk = 0, rst_n = 0, start = 0, sub = 0, cin = 0;
  logic [W-1:0] a = '0, b = '0;
  logic o_ready, o_busy, o_done, o_cout, o_ovf;
  logic [W-1:0] o_sum;
  logic [31:0] add_a, add_b, add_s;
  logic add_c0, add_cout;
  logic [32:0] add_r = '0;
  logic start2 = 0;
  logic [63:0] a2 = '0, b2 = '0, sum2;
  logic rdy2, bsy2, done2, cout2, ovf2, c02, ac2;
  logic [31:0] aa2, ab2, as2;
  int cyc = 0, errors = 0, checks = 0;
  int phase = 0;
  bit armed = 0;
  logic [W-1:0] ma = '0, mb = '0, msum = '0;
  logic mcin = 0, mcout = 0, movf = 0;
  logic [3:0] c0s;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) add_r <= {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_c0};
  assign {add_cout, add_s} = add_r;
  assign {ac2, as2} = {1'b0, aa2} + {1'b0, ab2} + {32'd0, c02};

  ksa_mw_seq #(.WORDS(WORDS), .LAT(LAT)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_a(a), .i_b(b), .i_sub(sub), .i_cin(cin),
    .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_sum(o_sum), .o_cout(o_cout), .o_ovf(o_ovf),
    .o_add_a(add_a), .o_add_b(add_b), .o_add_c0(add_c0), .i_add_s(add_s), .i_add_cout(add_cout));

  ksa_mw_seq #(.WORDS(2), .LAT(0)) dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_a(a2), .i_b(b2), .i_sub(1'b0), .i_cin(1'b0),
    .o_ready(rdy2), .o_busy(bsy2), .o_done(done2), .o_sum(sum2), .o_cout(cout2), .o_ovf(ovf2),
    .o_add_a(aa2), .o_add_b(ab2), .o_add_c0(c02), .i_add_s(as2), .i_add_cout(ac2));

  task automatic chk(input string name, input logic [W:0] act, input logic [W:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ovf_of(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] f;
    f = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    return (x[W-1] == y[W-1]) && (f[W-1] != x[W-1]);
  endfunction

  // carry into bit 32k of the full-width sum: what the adder must see as c0 for word k
  function automatic logic carry_into(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input int k);
    logic [W:0] m, t;
    m = ({{W{1'b0}}, 1'b1} << (32 * k)) - 1;
    t = ({1'b0, x} & m) + ({1'b0, y} & m) + {{W{1'b0}}, c};
    return t[32*k];
  endfunction

  always @(posedge clk) begin
    armed <= 1'b1;
    if (!rst_n) begin
      phase <= 0; msum <= '0; mcout <= 1'b0; movf <= 1'b0;
    end else if (start && (phase == 0 || phase == N)) begin
      phase <= 1; ma <= a; mb <= sub ? ~b : b; mcin <= sub | cin;
      msum <= '0; mcout <= 1'b0; movf <= 1'b0;
    end else if (phase == N) begin
      phase <= 0;
    end else if (phase != 0) begin
      phase <= phase + 1;
      if (phase == N - 1) begin
        {mcout, msum} <= {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
        movf <= ovf_of(ma, mb, mcin);
      end
    end
  end

  task automatic compare_cycle();
    bit be;
    int k;
    be = phase >= 1 && phase < N;
    k = be ? (phase - 1) / (LAT + 1) : 0;
    chk("ready", o_ready, !be);
    chk("busy", o_busy, be);
    chk("done", o_done, phase == N);
    if (!be) chk("sum", o_sum, msum);
    chk("cout", o_cout, mcout);
    chk("ovf", o_ovf, movf);
    chk("add_a", add_a, be ? ma[32*k +: 32] : 32'd0);
    chk("add_b", add_b, be ? mb[32*k +: 32] : 32'd0);
    chk("add_c0", add_c0, be ? carry_into(ma, mb, mcin, k) : 1'b0);
  endtask

  always @(negedge clk) if (armed) compare_cycle();

  task automatic op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input logic c, output int d);
    int c_start;
    @(posedge clk); #2;
    a = x; b = y; sub = s; cin = c; start = 1; c_start = cyc;
    @(posedge clk); #2;
    start = 0;
    d = -1;
    for (int i = 0; i < 40 && d < 0; i++) begin
      @(negedge clk);
      if ((cyc - c_start) % 2 == 1 && cyc - c_start <= 7) c0s[(cyc - c_start) / 2] = add_c0;
      if (o_done) d = cyc - c_start;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int d, c_start, d1, d2;
    logic [W-1:0] s1, s2;
    bit seen;
    repeat (3) @(posedge clk);
    #2 rst_n = 1;
    @(negedge clk);
    chk("rst_ready", o_ready, 1'b1);
    chk("rst_sum", o_sum, 128'd0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_add_b", add_b, 32'd0);

    op({W{1'b1}}, 128'd1, 1'b0, 1'b0, d);
    chk("ripple_done_cyc", d, 9);
    chk("ripple_sum", o_sum, 128'd0);
    chk("ripple_cout", o_cout, 1'b1);
    chk("ripple_ovf", o_ovf, 1'b0);
    chk("ripple_c0_seq", c0s, 4'b1110);

    op(128'd5, 128'd7, 1'b1, 1'b0, d);
    chk("sub_sum", o_sum, 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe);
    chk("sub_cout", o_cout, 1'b0);
    chk("sub_ovf", o_ovf, 1'b0);

    op(128'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff, 128'd1, 1'b0, 1'b0, d);
    chk("ovf_add_sum", o_sum, 128'h8000_0000_0000_0000_0000_0000_0000_0000);
    chk("ovf_add_ovf", o_ovf, 1'b1);
    chk("ovf_add_cout", o_cout, 1'b0);
    op(128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'd1, 1'b1, 1'b0, d);
    chk("ovf_sub_sum", o_sum, 128'h7fff_ffff_ffff_ffff_ffff_ffff_ffff_ffff);
    chk("ovf_sub_ovf", o_ovf, 1'b1);

    @(posedge clk); #2;
    a = 128'd1; b = 128'd2; sub = 0; cin = 0; start = 1; c_start = cyc;
    d1 = -1; d2 = -1; s1 = '0; s2 = '0;
    for (int r = 1; r <= 22; r++) begin
      @(posedge clk); #2;
      if (r == 2) start = 0;
      if (r == 3) begin start = 1; a = 128'd3; b = 128'd4; end
      if (r == 10) start = 0;
      @(negedge clk);
      if (o_done && d1 < 0) begin d1 = cyc - c_start; s1 = o_sum; end
      else if (o_done) begin d2 = cyc - c_start; s2 = o_sum; end
    end
    chk("hs_done1_cyc", d1, 9);
    chk("hs_sum1", s1, 128'd3);
    chk("hs_done2_cyc", d2, 18);
    chk("hs_sum2", s2, 128'd7);

    @(posedge clk); #2;
    a = 128'h1234_5678_9abc_def0_ffff_ffff_ffff_ffff; b = 128'd99; sub = 0; cin = 1; start = 1;
    for (int r = 1; r <= 5; r++) begin
      @(posedge clk); #2;
      if (r == 1) start = 0;
      if (r == 4) rst_n = 0;
      if (r == 5) rst_n = 1;
    end
    @(negedge clk);
    chk("rstmid_ready", o_ready, 1'b1);
    chk("rstmid_busy", o_busy, 1'b0);
    chk("rstmid_sum", o_sum, 128'd0);
    chk("rstmid_add_a", add_a, 32'd0);
    chk("rstmid_add_c0", add_c0, 1'b0);
    seen = 0;
    for (int r = 0; r < 12; r++) begin
      @(negedge clk);
      seen = seen | o_done;
    end
    chk("rstmid_no_done", seen, 1'b0);
    op(128'd10, 128'd20, 1'b0, 1'b0, d);
    chk("rstmid_after_cyc", d, 9);
    chk("rstmid_after_sum", o_sum, 128'd30);

    @(posedge clk); #2;
    a2 = 64'hffff_ffff; b2 = 64'd1; start2 = 1; c_start = cyc;
    @(posedge clk); #2;
    start2 = 0;
    d = -1;
    for (int i = 0; i < 20 && d < 0; i++) begin
      @(negedge clk);
      if (done2) d = cyc - c_start;
    end
    chk("lat0_done_cyc", d, 3);
    chk("lat0_sum", sum2, 64'h1_0000_0000);
    chk("lat0_cout", cout2, 1'b0);

    @(posedge clk); #2;
    a2 = 64'hffff_ffff_ffff_ffff; b2 = 64'd1; start2 = 1; c_start = cyc;
    @(posedge clk); #2;
    start2 = 0;
    d = -1;
    for (int i = 0; i < 20 && d < 0; i++) begin
      @(negedge clk);
      if (done2) d = cyc - c_start;
    end
    chk("lat0_wrap_cyc", d, 3);
    chk("lat0_wrap_sum", sum2, 64'd0);
    chk("lat0_wrap_cout", cout2, 1'b1);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
